// File: rtl/hrm_ctrl.sv
// Multi-cycle control unit for the HRM CPU: sequences each instruction through
// fetch, decode and execute and drives the datapath strobes and queue handshakes.
module hrm_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iInstr,
  input  logic       inboxEmpty,
  input  logic       outboxFull,
  input  logic       flagZ,
  input  logic       flagN,
  output logic       wIR,
  output logic       wPC,
  output logic       jmpPC,
  output logic [1:0] muxR,
  output logic       wR,
  output logic       wM,
  output logic       muxM,
  output logic [1:0] aluCtl,
  output logic       inboxRd,
  output logic       outboxWr,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_INBOX  = 3'd3,
    S_OUTBOX = 3'd4,
    S_MEMRD  = 3'd5,
    S_EXEC   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPUP   = 4'h6;
  localparam logic [3:0] OP_BUMPDN   = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [1:0] MUXR_INBOX = 2'b00;
  localparam logic [1:0] MUXR_MEM   = 2'b01;
  localparam logic [1:0] MUXR_ALU   = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_DEC = 2'b11;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_opcode;

  // Operand nibble is consumed by the datapath IR, not by the controller.
  logic w_unused_operand;
  assign w_unused_operand = ^iInstr[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opcode <= 4'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_FETCH) begin
        r_opcode <= iInstr[7:4];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    wIR      = 1'b0;
    wPC      = 1'b0;
    jmpPC    = 1'b0;
    muxR     = MUXR_INBOX;
    wR       = 1'b0;
    wM       = 1'b0;
    muxM     = 1'b0;
    aluCtl   = ALU_ADD;
    inboxRd  = 1'b0;
    outboxWr = 1'b0;
    halted   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        wIR          = 1'b1;
        w_state_next = S_DECODE;
      end

      S_DECODE: begin
        case (r_opcode)
          OP_INBOX:    w_state_next = S_INBOX;
          OP_OUTBOX:   w_state_next = S_OUTBOX;
          OP_COPYFROM,
          OP_ADD,
          OP_SUB,
          OP_BUMPUP,
          OP_BUMPDN:   w_state_next = S_MEMRD;
          OP_HALT:     w_state_next = S_HALT;
          default:     w_state_next = S_EXEC;
        endcase
      end

      // Queue status is used combinationally so a stall releases in the same cycle.
      S_INBOX: begin
        if (!inboxEmpty) begin
          inboxRd      = 1'b1;
          wR           = 1'b1;
          muxR         = MUXR_INBOX;
          wPC          = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_OUTBOX: begin
        if (!outboxFull) begin
          outboxWr     = 1'b1;
          wPC          = 1'b1;
          w_state_next = S_FETCH;
        end
      end

      S_MEMRD: begin
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        case (r_opcode)
          OP_COPYFROM: begin
            wR   = 1'b1;
            muxR = MUXR_MEM;
            wPC  = 1'b1;
          end
          OP_COPYTO: begin
            wM   = 1'b1;
            muxM = 1'b0;
            wPC  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            aluCtl = (r_opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            wR     = 1'b1;
            muxR   = MUXR_ALU;
            wPC    = 1'b1;
          end
          // Bumps write the ALU result to both R and the memory cell.
          OP_BUMPUP, OP_BUMPDN: begin
            aluCtl = (r_opcode == OP_BUMPDN) ? ALU_DEC : ALU_INC;
            wR     = 1'b1;
            muxR   = MUXR_ALU;
            wM     = 1'b1;
            muxM   = 1'b1;
            wPC    = 1'b1;
          end
          OP_JUMP: begin
            jmpPC = 1'b1;
          end
          OP_JUMPZ: begin
            jmpPC = flagZ;
            wPC   = ~flagZ;
          end
          OP_JUMPN: begin
            jmpPC = flagN;
            wPC   = ~flagN;
          end
          default: begin
            wPC = 1'b1;
          end
        endcase
      end

      S_HALT: begin
        halted       = 1'b1;
        w_state_next = S_HALT;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_hrm_ctrl.sv
// Directed bench for hrm_ctrl: every cycle's expected output vector is queued
// and compared against the DUT outputs mid-cycle.
module tb_hrm_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] iInstr;
  logic       inboxEmpty;
  logic       outboxFull;
  logic       flagZ;
  logic       flagN;
  logic       wIR;
  logic       wPC;
  logic       jmpPC;
  logic [1:0] muxR;
  logic       wR;
  logic       wM;
  logic       muxM;
  logic [1:0] aluCtl;
  logic       inboxRd;
  logic       outboxWr;
  logic       halted;
  logic [2:0] state;

  hrm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .iInstr     (iInstr),
    .inboxEmpty (inboxEmpty),
    .outboxFull (outboxFull),
    .flagZ      (flagZ),
    .flagN      (flagN),
    .wIR        (wIR),
    .wPC        (wPC),
    .jmpPC      (jmpPC),
    .muxR       (muxR),
    .wR         (wR),
    .wM         (wM),
    .muxM       (muxM),
    .aluCtl     (aluCtl),
    .inboxRd    (inboxRd),
    .outboxWr   (outboxWr),
    .halted     (halted),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {wIR,wPC,jmpPC,muxR,wR,wM,muxM,aluCtl,inboxRd,outboxWr,halted,state}
  logic [15:0] obs;
  assign obs = {wIR, wPC, jmpPC, muxR, wR, wM, muxM, aluCtl, inboxRd, outboxWr, halted, state};

  logic [15:0] sb[$];
  int n_pass;
  int n_total;

  function automatic logic [15:0] mk(input logic [2:0] st, input logic wir, input logic wpc,
                                     input logic jmp, input logic [1:0] mr, input logic wr,
                                     input logic wm, input logic mm, input logic [1:0] alu,
                                     input logic ird, input logic owr, input logic hlt);
    return {wir, wpc, jmp, mr, wr, wm, mm, alu, ird, owr, hlt, st};
  endfunction

  function automatic logic [15:0] idle_only(input logic [2:0] st);
    return mk(st, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
  endfunction

  task automatic cyc(input logic [15:0] exp, input string tag);
    logic [15:0] e;
    sb.push_back(exp);
    #2;
    e = sb.pop_front();
    n_total++;
    assert (obs === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [7:0] ins);
    $display("txn instr=%h t=%0t", ins, $time);
    iInstr = ins;
    cyc(mk(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "fetch");
    cyc(idle_only(3'd2), "decode");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    iInstr = 8'h30;
    inboxEmpty = 1'b0;
    outboxFull = 1'b0;
    flagZ = 1'b0;
    flagN = 1'b0;
    #2;
    inboxEmpty = 1'b1;
    outboxFull = 1'b1;
    flagZ = 1'b1;
    cyc(idle_only(3'd0), "reset_a");
    cyc(idle_only(3'd0), "reset_b");
    inboxEmpty = 1'b0;
    outboxFull = 1'b0;
    flagZ = 1'b0;
    rst = 1'b0;
    cyc(idle_only(3'd0), "idle_after_reset");

    // COPYTO
    fetch_decode(8'h30);
    cyc(mk(3'd6, 0, 1, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0), "copyto_exec");

    // INBOX stalled 5 cycles, then released
    inboxEmpty = 1'b1;
    fetch_decode(8'h00);
    for (int i = 0; i < 5; i++) cyc(idle_only(3'd3), "inbox_stall");
    inboxEmpty = 1'b0;
    cyc(mk(3'd3, 0, 1, 0, 2'd0, 1, 0, 0, 2'd0, 1, 0, 0), "inbox_pop");

    // BUMPDN
    fetch_decode(8'h75);
    cyc(idle_only(3'd5), "bumpdn_memrd");
    cyc(mk(3'd6, 0, 1, 0, 2'd3, 1, 1, 1, 2'd3, 0, 0, 0), "bumpdn_exec");

    // BUMPUP
    fetch_decode(8'h62);
    cyc(idle_only(3'd5), "bumpup_memrd");
    cyc(mk(3'd6, 0, 1, 0, 2'd3, 1, 1, 1, 2'd2, 0, 0, 0), "bumpup_exec");

    // ADD / SUB / COPYFROM
    fetch_decode(8'h41);
    cyc(idle_only(3'd5), "add_memrd");
    cyc(mk(3'd6, 0, 1, 0, 2'd3, 1, 0, 0, 2'd0, 0, 0, 0), "add_exec");
    fetch_decode(8'h51);
    cyc(idle_only(3'd5), "sub_memrd");
    cyc(mk(3'd6, 0, 1, 0, 2'd3, 1, 0, 0, 2'd1, 0, 0, 0), "sub_exec");
    fetch_decode(8'h27);
    cyc(idle_only(3'd5), "copyfrom_memrd");
    cyc(mk(3'd6, 0, 1, 0, 2'd1, 1, 0, 0, 2'd0, 0, 0, 0), "copyfrom_exec");

    // Conditional and unconditional jumps
    flagZ = 1'b1;
    fetch_decode(8'h93);
    cyc(mk(3'd6, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "jumpz_taken");
    flagZ = 1'b0;
    flagN = 1'b1;
    fetch_decode(8'h93);
    cyc(mk(3'd6, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "jumpz_not_taken");
    fetch_decode(8'hA4);
    cyc(mk(3'd6, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "jumpn_taken");
    flagN = 1'b0;
    flagZ = 1'b1;
    fetch_decode(8'hA4);
    cyc(mk(3'd6, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "jumpn_not_taken");
    flagZ = 1'b0;
    fetch_decode(8'h80);
    cyc(mk(3'd6, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "jump_exec");

    // OUTBOX without stall
    fetch_decode(8'h10);
    cyc(mk(3'd4, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0), "outbox_push");

    // NOP opcode C
    fetch_decode(8'hC0);
    cyc(mk(3'd6, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0), "nop_exec");

    // OUTBOX stalled, then reset lands mid-cycle
    outboxFull = 1'b1;
    fetch_decode(8'h10);
    for (int i = 0; i < 3; i++) cyc(idle_only(3'd4), "outbox_stall");
    #2;
    rst = 1'b1;
    cyc(idle_only(3'd0), "reset_mid_outbox");
    outboxFull = 1'b0;
    cyc(idle_only(3'd0), "reset_held");
    rst = 1'b0;
    cyc(idle_only(3'd0), "idle_after_abort");

    // HALT holds forever
    fetch_decode(8'hF0);
    inboxEmpty = 1'b0;
    flagZ = 1'b1;
    for (int i = 0; i < 10; i++) cyc(mk(3'd7, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 1), "halt_hold");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
